// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid port, decode valid/ready port,
// and the branch/jump redirect from the back end.
interface ifu_fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one request outstanding to instruction
// memory, buffers returned words in a small FIFO for decode, and handles redirects.
//
//   state  | meaning
//   S_REQ  | presenting mem_req at pc whenever the FIFO has a free slot
//   S_WAIT | one request granted, waiting for mem_rvalid (dropped if drop=1)
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ifu_fetch_ctrl_if.master  bus
);
  localparam int           PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]  DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt, req_pc;
  logic          drop, drop_nxt;
  logic          mem_req_q, req_nxt;
  logic [PW:0]   count, cnt_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fire, rsp, push, pop;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  always_comb begin
    fire      = mem_req_q & bus.mem_gnt;
    rsp       = (state == S_WAIT) & bus.mem_rvalid;
    push      = rsp & ~drop & ~bus.redirect_valid;
    pop       = (count != '0) & bus.inst_ready & ~bus.redirect_valid;
    state_nxt = state;
    drop_nxt  = drop;
    pc_nxt    = pc;
    case (state)
      S_REQ: begin
        if (fire) begin
          state_nxt = S_WAIT;
          drop_nxt  = bus.redirect_valid;
        end
      end
      S_WAIT: begin
        // A response coinciding with a redirect is discarded via push, so drop clears either way.
        if (rsp) begin
          state_nxt = S_REQ;
          drop_nxt  = 1'b0;
        end else if (bus.redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    if (bus.redirect_valid)
      pc_nxt = bus.redirect_pc & ~32'h3;
    else if (fire)
      pc_nxt = pc + 32'd4;
    if (bus.redirect_valid)
      cnt_nxt = '0;
    else
      cnt_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
    req_nxt = (state_nxt == S_REQ) && (cnt_nxt < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      drop      <= 1'b0;
      mem_req_q <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop      <= drop_nxt;
      mem_req_q <= req_nxt;
      count     <= cnt_nxt;
      if (fire)
        req_pc <= pc;
      if (bus.redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = fifo_data[rd_ptr];
  assign bus.inst_pc    = fifo_pc[rd_ptr];
endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the NPC core; owns the PC and drives the instruction ROM / instruction-memory port through a req/gnt/rvalid handshake.
- Buffers fetched words in a small FIFO and presents them to decode via valid/ready.
- Handles branch/jump redirects: flushes the FIFO and discards any stale in-flight response.
- Sits between the instruction memory and the IDU.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- FIFO_DEPTH, 2, entries in the fetch buffer; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch address, word aligned.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid for the single outstanding request.
- mem_rdata  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  PC of head instruction.
- redirect_valid  in  1  branch/jump taken; new fetch PC.
- redirect_pc  in  32  target; bits [1:0] ignored, treated as 0.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_REQ, FIFO empty, drop=0.
  - mem_req=0, inst_valid=0, mem_addr=RESET_PC.
- State S_REQ:
  - mem_req=1 iff FIFO count < FIFO_DEPTH; mem_addr=pc.
  - Once asserted, mem_req and mem_addr hold stable until mem_gnt, unless a redirect occurs.
  - On mem_req && mem_gnt: latch req_pc=pc, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 -> 0), go to S_WAIT.
- State S_WAIT:
  - mem_req=0. Exactly one request is outstanding; response latency is arbitrary, >= 1 cycle after gnt.
  - On mem_rvalid with drop=0: push {req_pc, mem_rdata}, go to S_REQ.
  - On mem_rvalid with drop=1: discard, clear drop, go to S_REQ.
  - A mem_rvalid in S_REQ is a protocol error and is ignored.
- Space rule: a request is issued only with a free slot. A push in S_WAIT can never overflow, even if decode stalls.
- FIFO:
  - Push and pop in the same cycle are allowed when full or empty (count unchanged when both).
  - Head outputs are registered FIFO contents; inst_valid = (count != 0).
  - No combinational path from mem_rdata to inst_data. Minimum fetch-to-valid latency is 1 cycle after rvalid.
- Redirect (redirect_valid=1), highest priority:
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed: count=0 next cycle; any pop that cycle is ignored.
  - In S_REQ without gnt: the request is abandoned; next cycle mem_addr = new pc.
  - In S_REQ with gnt the same cycle: go to S_WAIT with drop=1.
  - In S_WAIT without rvalid: drop<=1, stay in S_WAIT.
  - In S_WAIT with rvalid the same cycle: response discarded, drop stays 0, go to S_REQ.
  - Back-to-back redirects: the last one wins; drop is never more than 1 because only one request is outstanding.
- No instruction from before a redirect may ever appear on inst_* after the redirect cycle.
- inst_pc always equals the address that was granted for that word.

Test Plan:
- Reset release, memory gnt same cycle, rvalid next cycle, inst_ready=1:
  - Requests issue at 8000_0000, 8000_0004, 8000_0008.
  - inst_pc/inst_data appear in order, one word every 2 cycles.
- inst_ready=0 with FIFO_DEPTH=2:
  - Exactly 2 words buffered, then mem_req=0.
  - Raise inst_ready for one cycle -> one pop, one new request issued.
- Redirect to 8000_0100 while in S_WAIT; rvalid arrives 3 cycles later with 0xDEADBEEF:
  - Word discarded and never seen on inst_*.
  - Next request is at 8000_0100.
- Redirect to 8000_0200 in the same cycle as mem_rvalid: the response is dropped, no drop flag is left set, and the next request is at 8000_0200.
- Redirect in the same cycle as mem_gnt at 8000_0010:
  - The subsequent rvalid is discarded.
  - The following request is to the redirect target; redirect_pc=8000_0303 yields mem_addr=8000_0300.
- rst_n asserted mid-S_WAIT with 2 words buffered:
  - inst_valid=0 and mem_req=0 immediately (asynchronous).
  - After release, the first request is at RESET_PC and a late rvalid is ignored.
